// File: rtl/fetch_queue_if.sv
// Fetch-to-decode/imem/redirect bundle for fetch_queue.
// master = the fetch stage, slave = memory/decode/execute side.
interface fetch_queue_if #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned ADDR_WIDTH = 12
);
  logic [ADDR_WIDTH-1:0]    imem_addr;
  logic [XLEN-1:0]          imem_rdata;
  logic                     out_valid;
  logic                     out_ready;
  logic [XLEN-1:0]          out_pc;
  logic [XLEN-1:0]          out_instr;
  logic                     out_pred_taken;
  logic                     redirect_valid;
  logic [XLEN-1:0]          redirect_pc;
  logic [$clog2(DEPTH):0]   occupancy;

  modport master (
    output imem_addr,
    input  imem_rdata,
    output out_valid,
    input  out_ready,
    output out_pc,
    output out_instr,
    output out_pred_taken,
    input  redirect_valid,
    input  redirect_pc,
    output occupancy
  );

  modport slave (
    input  imem_addr,
    output imem_rdata,
    input  out_valid,
    output out_ready,
    input  out_pc,
    input  out_instr,
    input  out_pred_taken,
    output redirect_valid,
    output redirect_pc,
    input  occupancy
  );
endinterface

// File: rtl/fetch_queue.sv
// Fetch stage: owns the fetch PC, drives imem and buffers DEPTH {pc, instr} entries.
// Optional JAL predecode/static prediction enabled by defining FETCH_JAL_PREDECODE_EN.
module fetch_queue #(
  parameter int unsigned     XLEN       = 32,
  parameter int unsigned     DEPTH      = 4,
  parameter int unsigned     ADDR_WIDTH = 12,
  parameter logic [XLEN-1:0] RESET_PC   = '0
) (
  input logic           clk,
  input logic           rst,
  fetch_queue_if.master bus
);
  localparam int unsigned PtrW = $clog2(DEPTH);

  logic [XLEN-1:0] r_fetch_pc;
  logic [PtrW-1:0] r_rd_ptr;
  logic [PtrW-1:0] r_wr_ptr;
  logic [PtrW:0]   r_count;
  logic [XLEN-1:0] r_pc_q    [DEPTH];
  logic [XLEN-1:0] r_instr_q [DEPTH];

  logic            w_full;
  logic            w_out_valid;
  logic            w_deq;
  logic            w_enq;
  logic [XLEN-1:0] w_next_pc;
  logic [XLEN-1:0] w_redirect_pc;

  assign w_full        = (r_count == (PtrW + 1)'(DEPTH));
  assign w_out_valid   = (r_count != '0) && !bus.redirect_valid;
  assign w_deq         = w_out_valid && bus.out_ready;
  assign w_enq         = !bus.redirect_valid && (!w_full || w_deq);
  assign w_redirect_pc = bus.redirect_pc & ~XLEN'(3);

  assign bus.imem_addr = r_fetch_pc[ADDR_WIDTH-1:0];
  assign bus.out_valid = w_out_valid;
  assign bus.out_pc    = w_out_valid ? r_pc_q[r_rd_ptr] : '0;
  assign bus.out_instr = w_out_valid ? r_instr_q[r_rd_ptr] : '0;
  assign bus.occupancy = r_count;

`ifdef FETCH_JAL_PREDECODE_EN
  logic            r_pred_q [DEPTH];
  logic            w_is_jal;
  logic [XLEN-1:0] w_jal_imm;

  assign w_is_jal  = (bus.imem_rdata[6:0] == 7'b1101111);
  // J-type immediate, sign-extended to XLEN
  assign w_jal_imm = {{(XLEN-20){bus.imem_rdata[31]}}, bus.imem_rdata[19:12],
                      bus.imem_rdata[20], bus.imem_rdata[30:21], 1'b0};
  assign w_next_pc = r_fetch_pc + (w_is_jal ? w_jal_imm : XLEN'(4));
  assign bus.out_pred_taken = w_out_valid && r_pred_q[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) r_pred_q[i] <= 1'b0;
    end else if (w_enq) begin
      r_pred_q[r_wr_ptr] <= w_is_jal;
    end
  end
`else
  assign w_next_pc          = r_fetch_pc + XLEN'(4);
  assign bus.out_pred_taken = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_fetch_pc <= RESET_PC;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_pc_q[i]    <= '0;
        r_instr_q[i] <= '0;
      end
    end else if (bus.redirect_valid) begin
      // Stale entries stay in storage but are unreachable once count is zero.
      r_fetch_pc <= w_redirect_pc;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
    end else begin
      if (w_enq) begin
        r_pc_q[r_wr_ptr]    <= r_fetch_pc;
        r_instr_q[r_wr_ptr] <= bus.imem_rdata;
        r_wr_ptr            <= r_wr_ptr + 1'b1;
        r_fetch_pc          <= w_next_pc;
      end
      if (w_deq) r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + (PtrW + 1)'(w_enq) - (PtrW + 1)'(w_deq);
    end
  end
endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
Parametrised instruction fetch stage with a prefetch queue. It is the next-generation replacement for the bare PC register plus direct instruction-memory hookup in the single-cycle core. It owns the fetch PC, drives the combinational instruction memory, and buffers up to DEPTH fetched {PC, instruction} pairs. Instructions are handed to decode over a valid/ready handshake; execute can redirect fetch (branch/jump/JALR) and flush the queue.

Parameters:
XLEN, 32, width of PC and instruction word
DEPTH, 4, queue entries; power of two, >= 2
ADDR_WIDTH, 12, instruction memory address width (low PC bits)
RESET_PC, 32'h0000_0000, fetch PC after reset

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous active-low reset (0 = reset, sampled on rising edge of clk)
imem_addr  out  ADDR_WIDTH  instruction memory address = fetch_pc[ADDR_WIDTH-1:0]
imem_rdata  in  XLEN  instruction word, combinational from imem_addr
out_valid  out  1  head entry valid
out_ready  in  1  decode accepts head
out_pc  out  XLEN  PC of head entry
out_instr  out  XLEN  instruction of head entry
out_pred_taken  out  1  head entry was predicted taken (see Optional Feature)
redirect_valid  in  1  flush queue and restart fetch
redirect_pc  in  XLEN  restart address
occupancy  out  $clog2(DEPTH)+1  current entry count

Behaviour:
- Reset (rst==0 at a clock edge): fetch_pc=RESET_PC; rd_ptr=wr_ptr=0; count=0. Entries are cleared to 0. Reset has priority over everything, including mid-operation redirects and transfers.
- Outputs after reset: out_valid=0, out_pc=0, out_instr=0, out_pred_taken=0, occupancy=0, imem_addr=RESET_PC[ADDR_WIDTH-1:0].
- Defined signals:
  - deq = out_valid && out_ready
  - enq = !redirect_valid && (count<DEPTH || deq)
- out_valid = (count!=0) && !redirect_valid. During a redirect, no transfer occurs.
- out_pc, out_instr and out_pred_taken come from the head entry. They are forced to 0 when out_valid=0.
- On enq: write {fetch_pc, imem_rdata, pred} at wr_ptr; wr_ptr++ mod DEPTH; fetch_pc <= next_pc, where next_pc = fetch_pc+4 (wraps mod 2^XLEN).
- Full (count==DEPTH) without deq: no enqueue; fetch_pc and imem_addr hold.
- Full with deq in the same cycle: enqueue and dequeue both happen; count stays DEPTH.
- Empty: out_valid=0; enqueue only.
- On deq: rd_ptr++ mod DEPTH.
- count update: count += enq - deq.
- Redirect, cycle N (redirect_valid=1):
  - Edge ending N: count=0, rd_ptr=wr_ptr=0, fetch_pc = {redirect_pc[XLEN-1:2], 2'b00}.
  - Cycle N+1: imem_addr = target; the target is enqueued at the end of N+1.
  - Cycle N+2: out_valid=1, out_pc=target. The redirect penalty is 2 cycles.
- Back-to-back redirects: the last one wins; each one flushes.
- Steady state with out_ready=1: throughput is 1 instruction/cycle. Fill-to-output latency is 1 cycle (enqueue at edge, visible next cycle).
- Pointers wrap modulo DEPTH.
- occupancy = count, registered.

Optional Feature:
FETCH_JAL_PREDECODE_EN.
- Defined: each fetched word is predecoded.
  - If imem_rdata[6:0]==7'b1101111 (JAL): next_pc = fetch_pc + {{(XLEN-20){i[31]}}, i[19:12], i[20], i[30:21], 1'b0} and the entry's pred bit = 1.
  - Otherwise: next_pc = fetch_pc+4 and pred = 0.
  - Execute must not redirect on a JAL whose out_pred_taken=1.
- Undefined: next_pc is always fetch_pc+4, out_pred_taken is tied 0, and no predecode logic exists.

Test Plan:
- Reset, then out_ready=0 with the memory returning instr=PC: after 4 cycles occupancy=4; imem_addr holds 0x010; out_valid=1, out_pc=0x0, out_instr=0x0.
- Streaming with out_ready=1 from reset: out_valid first rises 1 cycle after reset release; out_pc then reads 0x0, 0x4, 0x8, ... one per cycle; occupancy stays 1.
- Full queue (occupancy=4) with out_ready=1 for one cycle: head 0x0 consumed, 0x10 enqueued, occupancy remains 4; next head is 0x4.
- Redirect_valid=1, redirect_pc=0x103 mid-stream:
  - Same cycle: out_valid=0.
  - Next cycle: occupancy=0, imem_addr=0x100.
  - Two cycles after: out_valid=1, out_pc=0x100; no stale entry ever appears.
- Hold rst=0 for one edge while the queue holds 3 entries and redirect_valid=1: all outputs return to reset values; fetch restarts at RESET_PC, not at redirect_pc.
- With FETCH_JAL_PREDECODE_EN, word 0x0100006F (jal x0,+16) at PC 0x8: next out_pc is 0x18 and out_pred_taken=1 for the 0x8 entry. Without the macro, the next out_pc is 0xC and out_pred_taken=0.
